// File: rtl/gmii_video_depacketizer.sv
// GMII receive-side video depacketizer: parses a fixed video header and packs
// each {G, B} payload byte pair with the frame's block/line tag into a FIFO word.
module gmii_video_depacketizer #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [10:0] PIXELS    = 11'd640
) (
    input  logic        i_clk_125M,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rxd,
    input  logic        i_rx_dv,
    input  logic        i_rx_er,
    input  logic        i_fifo_full,
    output logic [28:0] o_fifo_din,
    output logic        o_fifo_wr,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_drop_cnt,
    output logic        o_overflow
);

    typedef enum logic [2:0] {
        StIdle, StPreamble, StMacHdr, StVidHdr, StPixel, StTail, StDrop
    } state_t;

    state_t      r_state, w_state_d;
    logic        r_dv_prev;
    logic [10:0] r_cnt;      // MAC/video header byte index, or pixel index
    logic        r_odd;      // next payload byte is B
    logic [7:0]  r_eth_hi;
    logic [7:0]  r_g;
    logic [1:0]  r_x;
    logic [10:0] r_y;

    logic w_video;           // ethertype has matched and frame not yet complete
    logic w_drop_evt;
    logic w_pix_done;
    logic w_last_pix;

    assign w_video = (r_state == StVidHdr) || (r_state == StPixel);

    // State register.
    always_ff @(posedge i_clk_125M) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    // Next-state decode and per-cycle events.
    always_comb begin
        w_state_d  = r_state;
        w_drop_evt = 1'b0;
        w_pix_done = 1'b0;
        w_last_pix = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_rx_dv && !r_dv_prev) w_state_d = StPreamble;
            end
            StDrop: begin
                if (!i_rx_dv) w_state_d = StIdle;
            end
            default: begin
                if (i_rx_dv && i_rx_er) begin
                    w_state_d  = StDrop;
                    w_drop_evt = w_video;
                end else if (!i_rx_dv) begin
                    w_state_d  = StIdle;
                    w_drop_evt = w_video;
                end else begin
                    case (r_state)
                        StPreamble: begin
                            if (i_rxd == 8'hD5)      w_state_d = StMacHdr;
                            else if (i_rxd != 8'h55) w_state_d = StDrop;
                        end
                        StMacHdr: begin
                            if (r_cnt == 11'd13) begin
                                w_state_d = ({r_eth_hi, i_rxd} == ETHERTYPE) ? StVidHdr : StDrop;
                            end
                        end
                        StVidHdr: begin
                            if (r_cnt == 11'd1) w_state_d = StPixel;
                        end
                        StPixel: begin
                            if (r_odd) begin
                                w_pix_done = 1'b1;
                                if (r_cnt == PIXELS - 11'd1) begin
                                    w_last_pix = 1'b1;
                                    w_state_d  = StTail;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Byte counters, header capture, FIFO write and statistics.
    always_ff @(posedge i_clk_125M) begin
        if (!i_rst_n) begin
            r_dv_prev   <= 1'b1;
            r_cnt       <= '0;
            r_odd       <= 1'b0;
            r_eth_hi    <= '0;
            r_g         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            o_fifo_din  <= '0;
            o_fifo_wr   <= 1'b0;
            o_frame_cnt <= '0;
            o_drop_cnt  <= '0;
            o_overflow  <= 1'b0;
        end else begin
            r_dv_prev <= i_rx_dv;
            o_fifo_wr <= 1'b0;

            if (w_state_d != r_state) begin
                r_cnt <= '0;
                r_odd <= 1'b0;
            end else if (r_state == StMacHdr || r_state == StVidHdr) begin
                r_cnt <= r_cnt + 11'd1;
            end else if (r_state == StPixel) begin
                r_odd <= ~r_odd;
                if (r_odd) r_cnt <= r_cnt + 11'd1;
            end

            if (r_state == StMacHdr && r_cnt == 11'd12) r_eth_hi <= i_rxd;
            if (r_state == StVidHdr && r_cnt == 11'd0) begin
                r_x        <= i_rxd[4:3];
                r_y[10:8]  <= i_rxd[2:0];
            end
            if (r_state == StVidHdr && r_cnt == 11'd1) r_y[7:0] <= i_rxd;
            if (r_state == StPixel && !r_odd) r_g <= i_rxd;

            if (w_pix_done) begin
                if (!i_fifo_full) begin
                    o_fifo_din <= {r_x, r_y, r_g, i_rxd};
                    o_fifo_wr  <= 1'b1;
                end else begin
                    o_overflow <= 1'b1;
                end
            end
            if (w_last_pix) o_frame_cnt <= o_frame_cnt + 16'd1;
            if (w_drop_evt && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gmii_video_depacketizer.sv
// Randomized bench for gmii_video_depacketizer with a byte-position reference model.
module tb_gmii_video_depacketizer;

    localparam logic [15:0] ETH = 16'h88B5;
    localparam int NPIX = 640;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rxd;
    logic        rx_dv, rx_er, fifo_full;
    logic [28:0] fifo_din;
    logic        fifo_wr;
    logic [15:0] frame_cnt, drop_cnt;
    logic        overflow;

    gmii_video_depacketizer dut (
        .i_clk_125M (clk),
        .i_rst_n    (rst_n),
        .i_rxd      (rxd),
        .i_rx_dv    (rx_dv),
        .i_rx_er    (rx_er),
        .i_fifo_full(fifo_full),
        .o_fifo_din (fifo_din),
        .o_fifo_wr  (fifo_wr),
        .o_frame_cnt(frame_cnt),
        .o_drop_cnt (drop_cnt),
        .o_overflow (overflow)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [28:0] exp_q[$];
    logic [15:0] exp_frames = 16'd0;
    logic [15:0] exp_drops  = 16'd0;
    logic        exp_ovf    = 1'b0;
    logic [7:0]  pg[NPIX];
    logic [7:0]  pb[NPIX];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every write must match the oldest expected word and never follow another write directly.
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            check_eq("wr_spacing", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) check_eq("unexpected_wr", {3'd0, fifo_din}, 32'd0);
            else                   check_eq("fifo_din", {3'd0, fifo_din}, {3'd0, exp_q.pop_front()});
        end
        prev_wr = (fifo_wr === 1'b1);
    end

    // Sends one frame. npix pixel pairs are sent (FCS only when all are sent); rx_er pulses
    // on byte er_idx; fifo_full is forced on the B bytes of pixels full_lo..full_hi;
    // rst_rel >= 0 holds reset low until that byte index.
    task automatic send_frame(input logic [15:0] etype, input logic [1:0] x,
                              input logic [10:0] y, input int npix, input int er_idx,
                              input int full_lo, input int full_hi, input int rst_rel,
                              input bit det);
        int total;
        int comp;
        logic [7:0] vh0;
        logic [7:0] bt;
        vh0 = {3'($urandom), x, y[10:8]};
        for (int k = 0; k < NPIX; k++) begin
            pg[k] = det ? 8'(k) : 8'($urandom);
            pb[k] = det ? ~8'(k) : 8'($urandom);
        end
        total = 24 + 2 * npix + ((npix == NPIX) ? 4 : 0);

        // Reference model: decide outcome purely from byte positions.
        if (rst_rel >= 0) begin
            exp_frames = 16'd0;
            exp_drops  = 16'd0;
            exp_ovf    = 1'b0;
            exp_q.delete();
        end else if (etype == ETH) begin
            comp = 0;
            for (int k = 0; k < npix; k++) begin
                if (er_idx >= 0 && 24 + 2 * k + 1 >= er_idx) break;
                comp++;
                if (k >= full_lo && k <= full_hi) exp_ovf = 1'b1;
                else exp_q.push_back({x, y, pg[k], pb[k]});
            end
            if (comp == NPIX) exp_frames = exp_frames + 16'd1;
            else if (!(er_idx >= 0 && er_idx <= 21) && exp_drops != 16'hFFFF)
                exp_drops = exp_drops + 16'd1;
        end

        for (int i = 0; i < total; i++) begin
            if (i < 7)       bt = 8'h55;
            else if (i == 7) bt = 8'hD5;
            else if (i < 20) bt = 8'($urandom);
            else if (i == 20) bt = etype[15:8];
            else if (i == 21) bt = etype[7:0];
            else if (i == 22) bt = vh0;
            else if (i == 23) bt = y[7:0];
            else if (i < 24 + 2 * npix) bt = ((i - 24) % 2 == 0) ? pg[(i - 24) / 2] : pb[(i - 24) / 2];
            else bt = 8'($urandom);
            @(posedge clk);
            #1;
            rst_n = (rst_rel < 0 || i >= rst_rel);
            rx_dv = 1'b1;
            rx_er = (i == er_idx);
            rxd   = bt;
            if (i >= 24 && i < 24 + 2 * npix && (i - 24) % 2 == 1)
                fifo_full = ((i - 24) / 2 >= full_lo && (i - 24) / 2 <= full_hi);
            else
                fifo_full = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        fifo_full = 1'b0;
        rxd = 8'h00;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_eq("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames});
        check_eq("drop_cnt", {16'd0, drop_cnt}, {16'd0, exp_drops});
        check_eq("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        check_eq("writes_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int np, er, lo;
        rst_n = 1'b0;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        fifo_full = 1'b0;
        rxd = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_din", {3'd0, fifo_din}, 32'd0);
        check_eq("rst_wr", {31'd0, fifo_wr}, 32'd0);
        check_eq("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check_eq("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Deterministic frame: first word must be {1, 21F, 00, FF}.
        exp_q.delete();
        send_frame(ETH, 2'd1, 11'h21F, NPIX, -1, -1, -2, -1, 1'b1);
        send_frame(16'h0800, 2'd2, 11'h005, NPIX, -1, -1, -2, -1, 1'b0);
        send_frame(ETH, 2'd3, 11'h7FF, NPIX, -1, -1, -2, -1, 1'b0);
        send_frame(ETH, 2'd0, 11'h100, 100, -1, -1, -2, -1, 1'b0);
        send_frame(ETH, 2'd2, 11'h3A5, NPIX, -1, -1, -2, -1, 1'b0);
        send_frame(ETH, 2'd1, 11'h010, NPIX, -1, 10, 19, -1, 1'b0);
        send_frame(ETH, 2'd1, 11'h011, NPIX, 22, -1, -2, -1, 1'b0);
        send_frame(ETH, 2'd0, 11'h012, NPIX, 1303, -1, -2, -1, 1'b0);
        send_frame(ETH, 2'd0, 11'h013, NPIX, 1305, -1, -2, -1, 1'b0);
        send_frame(ETH, 2'd3, 11'h020, NPIX, -1, -1, -2, 300, 1'b0);
        send_frame(ETH, 2'd3, 11'h021, NPIX, -1, -1, -2, -1, 1'b0);

        for (int f = 0; f < 6; f++) begin
            np = ($urandom_range(0, 1) == 0) ? NPIX : $urandom_range(0, NPIX - 1);
            er = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 23 + 2 * np) : -1;
            lo = $urandom_range(0, NPIX - 1);
            send_frame(($urandom_range(0, 4) == 0) ? 16'h86DD : ETH, 2'($urandom),
                       11'($urandom), np, er, lo, lo + $urandom_range(0, 5), -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gmii_video_depacketizer.md
# gmii_video_depacketizer

Receives Ethernet frames on the GMII receive interface, parses a fixed video header, and converts each payload pixel pair into one 29-bit word pushed into the pixel FIFO. The word layout is {x_block[1:0], y_line[10:0], g[7:0], b[7:0]}. It is the direct upstream stage of the display data controller, which pops these words during active video. A frame carries half of one 1280-pixel line.

## Interface
- ETHERTYPE, 16'h88B5, ethertype that identifies a video frame
- PIXELS, 11'd640, pixels per frame (2 payload bytes each)
- i_clk_125M  in  1  GMII RX clock; all logic on its rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_rxd  in  8  GMII receive data
- i_rx_dv  in  1  GMII data valid
- i_rx_er  in  1  GMII receive error
- i_fifo_full  in  1  pixel FIFO full
- o_fifo_din  out  29  {x_block, y_line, g, b}
- o_fifo_wr  out  1  one-cycle FIFO write strobe
- o_frame_cnt  out  16  completed video frames (wraps)
- o_drop_cnt  out  16  malformed or aborted video frames (saturates at 16'hFFFF)
- o_overflow  out  1  sticky; set when a pixel is lost to i_fifo_full

## Operation
- Frame layout after SFD:
  - destination MAC, 6 bytes, ignored
  - source MAC, 6 bytes, ignored
  - ethertype, 2 bytes, MSB first
  - VH0 = {3'b0, x_block[1:0], y_line[10:8]}
  - VH1 = y_line[7:0]
  - PIXELS × {G, B}
  - FCS, 4 bytes, ignored (no CRC check)
- States: IDLE, PREAMBLE, MACHDR, VIDHDR, PIXEL, TAIL, DROP.
- IDLE → PREAMBLE only when i_rx_dv=1 and i_rx_dv was 0 in the previous cycle. This is a rising edge of dv, so a frame already in progress at reset release is skipped.
- PREAMBLE: byte 8'h55 stays; 8'hD5 → MACHDR; any other byte → DROP.
- MACHDR: counts 14 bytes. Ethertype ≠ ETHERTYPE → DROP (not counted in o_drop_cnt). Match → VIDHDR.
- VIDHDR: latch x_block and y_line from 2 bytes → PIXEL. Bits VH0[7:5] are ignored.
- PIXEL:
  - Even byte is latched as G; odd byte completes a pixel.
  - On each completed pixel: write if !i_fifo_full, else suppress the write and set o_overflow.
  - After pixel PIXELS-1 completes → TAIL and o_frame_cnt++.
- TAIL: consume bytes until i_rx_dv=0, then → IDLE.
- DROP: wait for i_rx_dv=0, then → IDLE.
- Abort rules:
  - i_rx_dv falls in PREAMBLE, MACHDR, VIDHDR or PIXEL: o_drop_cnt++ if the ethertype already matched; → IDLE.
  - i_rx_er=1 with i_rx_dv=1 in any state except IDLE or DROP: → DROP; o_drop_cnt++ if the ethertype already matched and the state was not TAIL.
- Pixels already written before an abort stay in the FIFO; no rollback.
- o_overflow clears only on reset.

## Timing
- Reset values:
  - state = IDLE
  - o_fifo_din = 0, o_fifo_wr = 0
  - o_frame_cnt = 0, o_drop_cnt = 0
  - o_overflow = 0
  - previous-dv register = 1, which forces a dv low/high edge before the first frame
- Pixel latency: o_fifo_wr and o_fifo_din are valid in the cycle after the edge that samples the B byte. o_fifo_din holds its value until the next write.
- o_fifo_wr is never high on two consecutive cycles. Minimum spacing is 2 cycles.
- i_fifo_full is sampled on the same edge as the B byte.
- Counter updates:
  - o_frame_cnt updates 1 cycle after the last B byte.
  - o_drop_cnt updates 1 cycle after the abort event.
- If i_rx_er and the dv fall occur in the same cycle, count once.
- A reset during a frame returns the block to IDLE. Remaining bytes of that frame are ignored until dv goes low.

## Test plan
- Good frame: 7×55, D5, 12 MAC bytes, 88 B5, VH=0A 1F (x=1, y=0x21F), 640×{G=i, B=~i}.
  - Required: 640 writes, first o_fifo_din = {2'd1, 11'h21F, 8'h00, 8'hFF}.
  - o_frame_cnt = 1, o_drop_cnt = 0.
- Ethertype 08 00 frame: no writes; both counters unchanged; next good frame is accepted normally.
- dv drops after 100 pixels: exactly 100 writes, o_drop_cnt = 1, then a good frame gives 640 writes and o_frame_cnt = 1.
- i_fifo_full held high during pixels 10–19 of a good frame: 630 writes, o_overflow = 1 and stays set, o_frame_cnt = 1.
- i_rx_er pulse during VIDHDR: no writes, o_drop_cnt = 1, bytes ignored until dv low.
- Release reset with dv already high mid-frame: no writes for that frame; the following frame is received complete.
